if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
- Pipeline register between the instruction-fetch unit and the decode stage of the P7 MIPS pipeline.
- Captures the fetched instruction and PC information each cycle, and tags fetch-address exceptions (AdEL).
- Tracks branch-delay-slot status and handles stall, interrupt flush and ERET flush.
- Exports a valid bit and a fetch counter so decode, CP0 and debug logic can identify bubbles.

Parameters:
- RESET_PC, 32'h00003000, PC value presented in D after reset.
- EXC_ADEL, 5'd4, exception code written when the fetch address is illegal.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Instr_F  input  32  instruction word from the fetch unit.
- ADD4_F  input  32  PC+4 of the fetched instruction.
- PCExc_F  input  1  fetch address illegal (misaligned or outside 0x3000..0x4FFF).
- Stall  input  1  hazard-unit stall; hold D contents.
- IntReq  input  1  CP0 interrupt/exception request; flush D.
- EXLClr  input  1  ERET taking effect; flush D.
- BranchD  input  1  instruction currently in D is a branch or jump.
- Instr_D  output  32  instruction presented to decode.
- PC_D  output  32  PC of Instr_D.
- PC8_D  output  32  PC_D+8 (link address for jal/jalr/bgezal).
- ExcCode_D  output  5  pending exception code; 0 = none.
- BD_D  output  1  Instr_D sits in a branch delay slot.
- Valid_D  output  1  D holds a real instruction, not a bubble.
- FetchCnt  output  32  number of instructions loaded into D since reset.

Behaviour:
- All registers update only on posedge clk. Outputs are pure register outputs; no combinational path from inputs to outputs.
- Priority each cycle: reset > IntReq > EXLClr > Stall > load.

Reset values:
- Instr_D=0, PC_D=RESET_PC, PC8_D=RESET_PC+8, ExcCode_D=0, BD_D=0, Valid_D=0, FetchCnt=0.

Flush (IntReq or EXLClr, not reset):
- Instr_D=0 (nop), ExcCode_D=0, BD_D=0, Valid_D=0.
- PC_D and PC8_D hold their previous values so CP0 has a stable PC for bubbles.
- FetchCnt unchanged.
- Flush overrides a simultaneous Stall.

Stall (no flush):
- All outputs hold, including BD_D and FetchCnt.

Load (no reset, flush or stall):
- PC_D = ADD4_F-4 and PC8_D = ADD4_F+4, both modulo 2^32.
- If PCExc_F=0: Instr_D=Instr_F, ExcCode_D=0.
- If PCExc_F=1: Instr_D=0 (fetched word discarded), ExcCode_D=EXC_ADEL.
- BD_D = BranchD, sampled in the same cycle: the incoming instruction is the delay slot of the instruction leaving D.
- Valid_D=1.
- FetchCnt increments by 1 and wraps from 32'hFFFFFFFF to 0. An AdEL-tagged load still counts.

Other rules:
- BD_D is set on load only; a stall never re-samples BranchD.
- ExcCode_D is cleared by flush, so a flushed AdEL never reaches CP0.
- Reset asserted mid-stall or mid-flush restores reset values on the next edge, regardless of the other inputs.

Test Plan:
- Reset then load: reset high 2 cycles; then Instr_F=32'h24010005, ADD4_F=32'h3004 -> after next edge Instr_D=24010005, PC_D=3000, PC8_D=3008, Valid_D=1, FetchCnt=1, ExcCode_D=0.
- Stall hold: with D loaded, Stall=1 for 3 cycles while Instr_F and ADD4_F change -> all outputs unchanged and FetchCnt constant; Stall=0 -> next value loads.
- AdEL tag: ADD4_F=32'h3006, PCExc_F=1, Instr_F=32'hFFFFFFFF -> Instr_D=0, PC_D=3002, ExcCode_D=4, Valid_D=1.
- Delay slot: D holds beq with BranchD=1, next load ADD4_F=32'h3010 -> BD_D=1, PC_D=300C; following load with BranchD=0 -> BD_D=0.
- Flush priority: Stall=1 and IntReq=1 in the same cycle -> Instr_D=0, Valid_D=0, BD_D=0, ExcCode_D=0, PC_D unchanged; repeat with EXLClr=1 -> same result.
- Counter wrap and reset mid-operation: force FetchCnt to FFFFFFFF, one load -> FetchCnt=0; assert reset during Stall=1 -> reset values next edge.

Source files
------------

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
//
// Pipeline register between instruction fetch (F) and decode (D) of the P7
// MIPS pipeline. Each cycle it either loads the fetched instruction and its
// PC information, holds (stall), or inserts a bubble (interrupt / ERET flush).
// Fetch-address errors are turned into an AdEL exception tag that travels
// with the bubble-ised instruction into decode.
//
// Parameters:
//   RESET_PC   PC shown in D after reset (PC8_D resets to RESET_PC+8)
//   EXC_ADEL   exception code used for an illegal fetch address
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   Instr_F    fetched instruction word
//   ADD4_F     PC+4 of the fetched instruction
//   PCExc_F    fetch address illegal (misaligned / out of range)
//   Stall      hold all D contents
//   IntReq     CP0 interrupt/exception request, flush D
//   EXLClr     ERET taking effect, flush D
//   BranchD    instruction currently in D is a branch/jump
//   Instr_D    instruction presented to decode
//   PC_D       PC of Instr_D
//   PC8_D      PC_D+8, link address
//   ExcCode_D  pending exception code, 0 = none
//   BD_D       Instr_D is in a branch delay slot
//   Valid_D    D holds a real instruction (not a bubble)
//   FetchCnt   instructions loaded into D since reset (wraps)
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// ---------------------------------------------------------------------------
module if_id_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [4:0]  EXC_ADEL = 5'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr_F,
   input  logic [31:0] ADD4_F,
   input  logic        PCExc_F,
   input  logic        Stall,
   input  logic        IntReq,
   input  logic        EXLClr,
   input  logic        BranchD,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC8_D,
   output logic [4:0]  ExcCode_D,
   output logic        BD_D,
   output logic        Valid_D,
   output logic [31:0] FetchCnt
);

   localparam logic [31:0] RESET_PC8 = RESET_PC + 32'd8;

   logic [31:0] instr_q,     instr_d;
   logic [31:0] pc_q,        pc_d;
   logic [31:0] pc8_q,       pc8_d;
   logic [4:0]  exc_code_q,  exc_code_d;
   logic        bd_q,        bd_d;
   logic        valid_q,     valid_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   logic        flush;

   // Either an interrupt entry or an ERET turns D into a bubble; both win
   // over a simultaneous stall.
   assign flush = IntReq | EXLClr;

   always_comb begin
      // Default: hold everything (covers the stall case)
      instr_d     = instr_q;
      pc_d        = pc_q;
      pc8_d       = pc8_q;
      exc_code_d  = exc_code_q;
      bd_d        = bd_q;
      valid_d     = valid_q;
      fetch_cnt_d = fetch_cnt_q;

      if (flush) begin
         // PC/PC8 are left alone so CP0 still sees a stable PC for the bubble;
         // clearing the exception code drops any AdEL that was waiting in D.
         instr_d    = 32'd0;
         exc_code_d = 5'd0;
         bd_d       = 1'b0;
         valid_d    = 1'b0;
      end else if (!Stall) begin
         pc_d        = ADD4_F - 32'd4;
         pc8_d       = ADD4_F + 32'd4;
         // A bad fetch address means the word on Instr_F is garbage: replace
         // it with a nop and tag the slot with AdEL instead.
         instr_d     = PCExc_F ? 32'd0 : Instr_F;
         exc_code_d  = PCExc_F ? EXC_ADEL : 5'd0;
         // The incoming instruction is the delay slot of whatever is leaving D.
         bd_d        = BranchD;
         valid_d     = 1'b1;
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q     <= 32'd0;
         pc_q        <= RESET_PC;
         pc8_q       <= RESET_PC8;
         exc_code_q  <= 5'd0;
         bd_q        <= 1'b0;
         valid_q     <= 1'b0;
         fetch_cnt_q <= 32'd0;
      end else begin
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         pc8_q       <= pc8_d;
         exc_code_q  <= exc_code_d;
         bd_q        <= bd_d;
         valid_q     <= valid_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign Instr_D   = instr_q;
   assign PC_D      = pc_q;
   assign PC8_D     = pc8_q;
   assign ExcCode_D = exc_code_q;
   assign BD_D      = bd_q;
   assign Valid_D   = valid_q;
   assign FetchCnt  = fetch_cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_reg
//
// Directed vector table for the documented scenarios, a hand-written counter
// wrap / reset-during-stall sequence, then randomized traffic compared against
// a behavioural model of the D-stage contents.
// ---------------------------------------------------------------------------
module tb_if_id_reg;

   logic        clk;
   logic        reset;
   logic [31:0] Instr_F;
   logic [31:0] ADD4_F;
   logic        PCExc_F;
   logic        Stall;
   logic        IntReq;
   logic        EXLClr;
   logic        BranchD;
   logic [31:0] Instr_D;
   logic [31:0] PC_D;
   logic [31:0] PC8_D;
   logic [4:0]  ExcCode_D;
   logic        BD_D;
   logic        Valid_D;
   logic [31:0] FetchCnt;

   int checks = 0;
   int errors = 0;

   if_id_reg #(
      .RESET_PC (32'h0000_3000),
      .EXC_ADEL (5'd4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .Instr_F   (Instr_F),
      .ADD4_F    (ADD4_F),
      .PCExc_F   (PCExc_F),
      .Stall     (Stall),
      .IntReq    (IntReq),
      .EXLClr    (EXLClr),
      .BranchD   (BranchD),
      .Instr_D   (Instr_D),
      .PC_D      (PC_D),
      .PC8_D     (PC8_D),
      .ExcCode_D (ExcCode_D),
      .BD_D      (BD_D),
      .Valid_D   (Valid_D),
      .FetchCnt  (FetchCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic [31:0] add4;
      logic        pcexc;
      logic        stall;
      logic        intreq;
      logic        exlclr;
      logic        branch;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic [31:0] e_pc8;
      logic [4:0]  e_exc;
      logic        e_bd;
      logic        e_valid;
      logic [31:0] e_cnt;
   } vec_t;

   localparam int NVEC = 18;
   vec_t tbl [NVEC];

   function automatic vec_t mk(input logic rst, input logic [31:0] instr, input logic [31:0] add4,
                               input logic pcexc, input logic stall, input logic intreq,
                               input logic exlclr, input logic branch,
                               input logic [31:0] e_instr, input logic [31:0] e_pc,
                               input logic [31:0] e_pc8, input logic [4:0] e_exc,
                               input logic e_bd, input logic e_valid, input logic [31:0] e_cnt);
      vec_t v;
      v.rst = rst; v.instr = instr; v.add4 = add4; v.pcexc = pcexc; v.stall = stall;
      v.intreq = intreq; v.exlclr = exlclr; v.branch = branch;
      v.e_instr = e_instr; v.e_pc = e_pc; v.e_pc8 = e_pc8; v.e_exc = e_exc;
      v.e_bd = e_bd; v.e_valid = e_valid; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic drive(input logic rst, input logic [31:0] instr, input logic [31:0] add4,
                        input logic pcexc, input logic stall, input logic intreq,
                        input logic exlclr, input logic branch);
      reset   = rst;
      Instr_F = instr;
      ADD4_F  = add4;
      PCExc_F = pcexc;
      Stall   = stall;
      IntReq  = intreq;
      EXLClr  = exlclr;
      BranchD = branch;
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                            input logic [31:0] e_pc8, input logic [4:0] e_exc, input logic e_bd,
                            input logic e_valid, input logic [31:0] e_cnt);
      chk32({tag, ".Instr_D"},   Instr_D,          e_instr);
      chk32({tag, ".PC_D"},      PC_D,             e_pc);
      chk32({tag, ".PC8_D"},     PC8_D,            e_pc8);
      chk32({tag, ".ExcCode_D"}, {27'd0, ExcCode_D}, {27'd0, e_exc});
      chk32({tag, ".BD_D"},      {31'd0, BD_D},    {31'd0, e_bd});
      chk32({tag, ".Valid_D"},   {31'd0, Valid_D}, {31'd0, e_valid});
      chk32({tag, ".FetchCnt"},  FetchCnt,         e_cnt);
   endtask

   // Behavioural model of what the decode stage should be holding
   logic [31:0] m_instr, m_pc, m_pc8, m_cnt;
   logic [4:0]  m_exc;
   logic        m_bd, m_valid;

   task automatic model_step(input logic rst, input logic [31:0] instr, input logic [31:0] add4,
                             input logic pcexc, input logic stall, input logic intreq,
                             input logic exlclr, input logic branch);
      if (rst) begin
         m_instr = 0; m_pc = 32'h3000; m_pc8 = 32'h3008; m_exc = 0;
         m_bd = 0; m_valid = 0; m_cnt = 0;
      end else if (intreq || exlclr) begin
         // bubble: nop, no exception, PC kept
         m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      end else if (!stall) begin
         m_pc    = add4 - 4;
         m_pc8   = add4 + 4;
         m_instr = pcexc ? 32'd0 : instr;
         m_exc   = pcexc ? 5'd4 : 5'd0;
         m_bd    = branch;
         m_valid = 1;
         m_cnt   = m_cnt + 1;
      end
   endtask

   initial begin
      //            rst instr         add4          exc stl int erc br   e_instr       e_pc          e_pc8         exc bd v  cnt
      tbl[0]  = mk(1, 32'h0,        32'h0,        0,  0,  0,  0,  0,   32'h0,        32'h3000,     32'h3008,     0,  0, 0, 0);
      tbl[1]  = mk(1, 32'h1234,     32'h5000,     1,  1,  1,  1,  1,   32'h0,        32'h3000,     32'h3008,     0,  0, 0, 0);
      tbl[2]  = mk(0, 32'h24010005, 32'h3004,     0,  0,  0,  0,  0,   32'h24010005, 32'h3000,     32'h3008,     0,  0, 1, 1);
      tbl[3]  = mk(0, 32'hDEADBEEF, 32'h4000,     0,  1,  0,  0,  0,   32'h24010005, 32'h3000,     32'h3008,     0,  0, 1, 1);
      tbl[4]  = mk(0, 32'h11111111, 32'h3100,     1,  1,  0,  0,  0,   32'h24010005, 32'h3000,     32'h3008,     0,  0, 1, 1);
      tbl[5]  = mk(0, 32'h22222222, 32'h3200,     0,  1,  0,  0,  1,   32'h24010005, 32'h3000,     32'h3008,     0,  0, 1, 1);
      tbl[6]  = mk(0, 32'h10220003, 32'h3008,     0,  0,  0,  0,  0,   32'h10220003, 32'h3004,     32'h300C,     0,  0, 1, 2);
      tbl[7]  = mk(0, 32'h24020001, 32'h3010,     0,  0,  0,  0,  1,   32'h24020001, 32'h300C,     32'h3014,     0,  1, 1, 3);
      tbl[8]  = mk(0, 32'h24030002, 32'h3014,     0,  0,  0,  0,  0,   32'h24030002, 32'h3010,     32'h3018,     0,  0, 1, 4);
      tbl[9]  = mk(0, 32'hFFFFFFFF, 32'h3006,     1,  0,  0,  0,  0,   32'h0,        32'h3002,     32'h300A,     4,  0, 1, 5);
      tbl[10] = mk(0, 32'h12345678, 32'h3020,     0,  1,  1,  0,  1,   32'h0,        32'h3002,     32'h300A,     0,  0, 0, 5);
      tbl[11] = mk(0, 32'h8C010000, 32'h301C,     0,  0,  0,  0,  1,   32'h8C010000, 32'h3018,     32'h3020,     0,  1, 1, 6);
      tbl[12] = mk(0, 32'h87654321, 32'h3040,     0,  1,  0,  1,  0,   32'h0,        32'h3018,     32'h3020,     0,  0, 0, 6);
      tbl[13] = mk(0, 32'h55555555, 32'h3044,     0,  0,  1,  1,  1,   32'h0,        32'h3018,     32'h3020,     0,  0, 0, 6);
      tbl[14] = mk(0, 32'hAAAA5555, 32'h00000000, 1,  0,  0,  0,  0,   32'h0,        32'hFFFFFFFC, 32'h00000004, 4,  0, 1, 7);
      tbl[15] = mk(0, 32'h33333333, 32'h3050,     0,  1,  0,  0,  1,   32'h0,        32'hFFFFFFFC, 32'h00000004, 4,  0, 1, 7);
      tbl[16] = mk(1, 32'h44444444, 32'h3060,     1,  1,  1,  0,  1,   32'h0,        32'h3000,     32'h3008,     0,  0, 0, 0);
      tbl[17] = mk(0, 32'h01234567, 32'hFFFFFFFC, 0,  0,  0,  0,  0,   32'h01234567, 32'hFFFFFFF8, 32'h00000000, 0,  0, 1, 1);

      drive(1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      // Directed table: one cycle per entry, checked on the following falling edge
      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i].rst, tbl[i].instr, tbl[i].add4, tbl[i].pcexc, tbl[i].stall,
               tbl[i].intreq, tbl[i].exlclr, tbl[i].branch);
         @(negedge clk);
         check_all($sformatf("vec%0d", i), tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_pc8,
                   tbl[i].e_exc, tbl[i].e_bd, tbl[i].e_valid, tbl[i].e_cnt);
      end

      // Counter wrap: preload the count, then one load must roll it to zero
      drive(0, 32'h0, 32'h3000, 0, 1, 0, 0, 0);
      force dut.fetch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_cnt_q;
      @(negedge clk);
      chk32("wrap.preload", FetchCnt, 32'hFFFF_FFFF);
      drive(0, 32'h2408000A, 32'h3024, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_all("wrap.load", 32'h2408000A, 32'h3020, 32'h3028, 0, 0, 1, 32'h0);
      drive(0, 32'h2409000B, 32'h3028, 1, 0, 0, 0, 0);
      @(negedge clk);
      check_all("wrap.adel", 32'h0, 32'h3024, 32'h302C, 4, 0, 1, 32'h1);

      // Reset while stalled restores reset values regardless of the rest
      drive(1, 32'hCAFEBABE, 32'h3100, 0, 1, 0, 0, 1);
      @(negedge clk);
      check_all("rst_stall", 32'h0, 32'h3000, 32'h3008, 0, 0, 0, 32'h0);

      // Randomized traffic against the model; first cycle is a reset to align state
      for (int n = 0; n < 400; n++) begin
         logic        r_rst, r_exc, r_stl, r_int, r_erc, r_br;
         logic [31:0] r_instr, r_add4;
         r_rst   = (n == 0) || ($urandom_range(0, 39) == 0);
         r_exc   = ($urandom_range(0, 7) == 0);
         r_stl   = ($urandom_range(0, 3) == 0);
         r_int   = ($urandom_range(0, 9) == 0);
         r_erc   = ($urandom_range(0, 9) == 0);
         r_br    = $urandom_range(0, 1) == 1;
         r_instr = $urandom;
         r_add4  = ($urandom_range(0, 15) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 2047) << 2));
         drive(r_rst, r_instr, r_add4, r_exc, r_stl, r_int, r_erc, r_br);
         model_step(r_rst, r_instr, r_add4, r_exc, r_stl, r_int, r_erc, r_br);
         @(negedge clk);
         check_all($sformatf("rnd%0d", n), m_instr, m_pc, m_pc8, m_exc, m_bd, m_valid, m_cnt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
